cbu_mod8_up_counter: RTL and testbench

CBU_MOD8_UP_COUNTER -- requirements
Module: cbu_mod8_up_counter

---
 rtl/cbu_mod8_up_counter.sv | 90 +++++++++
 tb/tb_cbu_mod8_up_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cbu_mod8_up_counter.sv
`default_nettype none
// ============================================================================
// Module      : cbu_mod8_up_counter
// Description : 8-bit cascadable modulo up-counter with synchronous load,
//               programmable terminal count (MAX), combinational carry-out
//               for same-cycle cascading and a registered one-cycle wrap
//               pulse (TC).
//               Optional feature: define CBU_STICKY_OVF_EN to add the sticky
//               wrap flag output OVF.
// Revision    : 1.0 - initial release
// ============================================================================
module cbu_mod8_up_counter #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       CLK,
    input  logic       CDN,
    input  logic       CAI,
    input  logic       EN,
    input  logic       LD,
    input  logic [7:0] D,
    input  logic [7:0] MAX,
    output logic [7:0] Q,
    output logic       CAO,
`ifdef CBU_STICKY_OVF_EN
    output logic       TC,
    output logic       OVF
`else
    output logic       TC
`endif
);

    logic [7:0] r_q;
    logic       r_tc;
    logic       w_count;
    logic       w_term;

    // A count edge needs carry-in and enable, and is pre-empted by a load.
    assign w_count = CAI & EN & ~LD;

    // Anything at or above MAX is terminal, so a loaded value beyond MAX
    // wraps straight to zero instead of counting upward.
    assign w_term  = (r_q >= MAX);

    // Carry-out is purely combinational so a downstream stage advances on
    // the same edge that this stage wraps.
    assign CAO = w_count & w_term;

    assign Q  = r_q;
    assign TC = r_tc;

    // Count register and wrap pulse: reset, then load, then count, else hold.
    always_ff @(posedge CLK) begin
        if (!CDN) begin
            r_q  <= RESET_VAL;
            r_tc <= 1'b0;
        end else if (LD) begin
            r_q  <= D;
            r_tc <= 1'b0;
        end else if (w_count) begin
            if (w_term) begin
                r_q  <= 8'h00;
                r_tc <= 1'b1;
            end else begin
                r_q  <= r_q + 8'd1;
                r_tc <= 1'b0;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

`ifdef CBU_STICKY_OVF_EN
    logic r_ovf;

    assign OVF = r_ovf;

    // Sticky wrap flag: set by any wrap, cleared only by reset or load.
    always_ff @(posedge CLK) begin
        if (!CDN) begin
            r_ovf <= 1'b0;
        end else if (LD) begin
            r_ovf <= 1'b0;
        end else if (w_count && w_term) begin
            r_ovf <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cbu_mod8_up_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbu_mod8_up_counter
// Description : Self-checking bench for cbu_mod8_up_counter. A reference
//               model predicts each edge's result, pushes it to a queue, and
//               the value is popped and compared once the DUT has clocked.
//               A second instance is cascaded from the first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cbu_mod8_up_counter;

    localparam logic [7:0] c_RESET_VAL = 8'h00;

    typedef struct packed {
        logic [7:0] q;
        logic       tc;
        logic       ovf;
    } exp_t;

    logic       CLK = 1'b0;
    logic       CDN = 1'b1;
    logic       CAI = 1'b0;
    logic       EN  = 1'b0;
    logic       LD  = 1'b0;
    logic [7:0] D   = 8'h00;
    logic [7:0] MAX = 8'h00;
    logic [7:0] Q;
    logic       CAO;
    logic       TC;

    logic       cdn1 = 1'b1;
    logic       en1  = 1'b0;
    logic [7:0] q1;
    logic       cao1;
    logic       tc1;

`ifdef CBU_STICKY_OVF_EN
    logic       OVF;
    logic       ovf1;
`endif

    int checks = 0;
    int errors = 0;

    exp_t       sb[$];
    logic [7:0] m_q   = 8'h00;
    logic       m_tc  = 1'b0;
    logic       m_ovf = 1'b0;
    bit         m_valid = 1'b0;

    always #5 CLK = ~CLK;

    cbu_mod8_up_counter #(.RESET_VAL(c_RESET_VAL)) dut0 (
        .CLK (CLK),
        .CDN (CDN),
        .CAI (CAI),
        .EN  (EN),
        .LD  (LD),
        .D   (D),
        .MAX (MAX),
        .Q   (Q),
        .CAO (CAO),
`ifdef CBU_STICKY_OVF_EN
        .TC  (TC),
        .OVF (OVF)
`else
        .TC  (TC)
`endif
    );

    cbu_mod8_up_counter #(.RESET_VAL(c_RESET_VAL)) dut1 (
        .CLK (CLK),
        .CDN (cdn1),
        .CAI (CAO),
        .EN  (en1),
        .LD  (1'b0),
        .D   (8'h00),
        .MAX (8'hFF),
        .Q   (q1),
        .CAO (cao1),
`ifdef CBU_STICKY_OVF_EN
        .TC  (tc1),
        .OVF (ovf1)
`else
        .TC  (tc1)
`endif
    );

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock edge on dut0: drive at negedge, check CAO, predict, clock, compare.
    task automatic step(input logic cdn, input logic ld, input logic en,
                        input logic cai, input logic [7:0] d, input logic [7:0] max);
        exp_t e;
        logic exp_cao;
        @(negedge CLK);
        CDN = cdn; LD = ld; EN = en; CAI = cai; D = d; MAX = max;
        #1;
        if (m_valid) begin
            exp_cao = cai & en & ~ld & (m_q >= max);
            chk1("cao", CAO, exp_cao);
        end
        if (!cdn) begin
            m_q = c_RESET_VAL; m_tc = 1'b0; m_ovf = 1'b0;
        end else if (ld) begin
            m_q = d; m_tc = 1'b0; m_ovf = 1'b0;
        end else if (en && cai) begin
            if (m_q >= max) begin
                m_q = 8'h00; m_tc = 1'b1; m_ovf = 1'b1;
            end else begin
                m_q = m_q + 8'd1; m_tc = 1'b0;
            end
        end else begin
            m_tc = 1'b0;
        end
        if (!cdn) m_valid = 1'b1;
        e.q = m_q; e.tc = m_tc; e.ovf = m_ovf;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk8("q", Q, e.q);
            chk1("tc", TC, e.tc);
`ifdef CBU_STICKY_OVF_EN
            chk1("ovf", OVF, e.ovf);
`endif
        end
    endtask

    initial begin
        // Reset, MAX=9
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd9);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd9);
        chk8("reset_q", Q, c_RESET_VAL);
        chk1("reset_tc", TC, 1'b0);

        // 12 enabled edges: 1..9,0,1,2
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'd9);
        chk8("mod10_final", Q, 8'd2);

        // Load above MAX, next count wraps to 0
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h20, 8'h10);
        chk8("load_20", Q, 8'h20);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h10);
        chk8("wrap_from_above", Q, 8'h00);
        chk1("wrap_from_above_tc", TC, 1'b1);

        // Reset overrides load
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 8'h10);
        chk8("reset_over_ld", Q, c_RESET_VAL);

        // Load 3, CAI=0 holds for 5 edges
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h03, 8'h03);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03);
        chk8("cai0_hold", Q, 8'h03);

        // EN=0 hold
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h09);

        // MAX=0: Q stays 0, TC continuous
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
        chk1("max0_tc", TC, 1'b1);

        // MAX change mid-count takes effect on next comparison
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h05);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h05);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h02);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h02);

        // MAX=FF: FE -> FF -> 00 with TC
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hFE, 8'hFF);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF);
        chk8("ff_wrap_q", Q, 8'h00);
        chk1("ff_wrap_tc", TC, 1'b1);

`ifdef CBU_STICKY_OVF_EN
        // Sticky overflow: set on wrap, held, cleared by load
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h02);
        chk1("ovf_sticky", OVF, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02);
        chk1("ovf_held", OVF, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02);
        chk1("ovf_cleared", OVF, 1'b0);
`endif

        // Cascade: reset both, 256 enabled edges on stage0 with MAX=FF
        @(negedge CLK);
        cdn1 = 1'b0; en1 = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF);
        chk8("casc_reset_q1", q1, 8'h00);
        @(negedge CLK);
        cdn1 = 1'b1;
        for (int i = 0; i < 255; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF);
        chk8("casc_q1_before", q1, 8'h00);
        chk1("casc_cao0_at_ff", CAO, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF);
        chk8("casc_q0", Q, 8'h00);
        chk8("casc_q1", q1, 8'h01);
        chk1("casc_tc1", tc1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
